// File: rtl/ofdm_symbol_buffer_if.sv
// Avalon-ST style sample stream used on both sides of the OFDM symbol buffer.
// The master drives the beat and the slave drives ready.
interface ofdm_symbol_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  startofpacket;
    logic                  endofpacket;

    modport master (
        output data, valid, startofpacket, endofpacket,
        input  ready
    );

    modport slave (
        input  data, valid, startofpacket, endofpacket,
        output ready
    );
endinterface

// File: rtl/ofdm_symbol_buffer.sv
// Ping-pong symbol store between the symbol synchroniser and the FFT.
// Captures framed 64-sample packets and replays them gap-free in natural or bit-reversed order.
module ofdm_symbol_buffer #(
    parameter int unsigned OFDM_SYMBOL_LENGTH = 64,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter bit          BIT_REVERSE        = 1'b0
) (
    input  logic                        clock_clk,
    input  logic                        reset_reset_n,
    ofdm_symbol_buffer_if.slave         asi_in0,
    ofdm_symbol_buffer_if.master        aso_out0,
    output logic                        symbol_drop,
    output logic                        length_error
);

    localparam int unsigned LEN = OFDM_SYMBOL_LENGTH;
    localparam int unsigned AW  = $clog2(LEN);
    localparam logic [AW-1:0] LAST = AW'(LEN - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_SKIP} w_state_t;
    typedef enum logic       {R_IDLE, R_SEND}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [2][LEN];

    w_state_t              w_state_q, w_state_d;
    logic [AW-1:0]         windex_q, windex_d;
    logic                  wbank_q, wbank_d;
    logic                  we_c;
    logic [AW-1:0]         waddr_c;
    logic                  commit_c;
    logic                  drop_d, lerr_d;

    r_state_t              r_state_q, r_state_d;
    logic [AW-1:0]         rindex_q, rindex_d;
    logic [AW-1:0]         rnext_c;
    logic                  rbank_q, rbank_d;
    logic                  release_c;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;

    logic [1:0]            full_q, full_d;
    logic                  drop_q, lerr_q;

    function automatic logic [AW-1:0] map_idx(input logic [AW-1:0] k);
        logic [AW-1:0] r;
        r = k;
        if (BIT_REVERSE) begin
            for (int unsigned i = 0; i < AW; i++) r[i] = k[AW-1-i];
        end
        return r;
    endfunction

    // Sink never stalls the synchroniser.
    assign asi_in0.ready          = 1'b1;
    assign aso_out0.data          = data_q;
    assign aso_out0.valid         = valid_q;
    assign aso_out0.startofpacket = sop_q;
    assign aso_out0.endofpacket   = eop_q;
    assign symbol_drop            = drop_q;
    assign length_error           = lerr_q;

    // Write side: framing check and capture into the current write bank.
    always_comb begin
        w_state_d = w_state_q;
        windex_d  = windex_q;
        wbank_d   = wbank_q;
        we_c      = 1'b0;
        waddr_c   = windex_q;
        commit_c  = 1'b0;
        drop_d    = 1'b0;
        lerr_d    = 1'b0;
        case (w_state_q)
            W_IDLE, W_SKIP: begin
                if (asi_in0.valid) begin
                    if (asi_in0.startofpacket) begin
                        if (full_q[wbank_q]) begin
                            drop_d    = 1'b1;
                            w_state_d = asi_in0.endofpacket ? W_IDLE : W_SKIP;
                        end else if (asi_in0.endofpacket) begin
                            // A single-beat packet can never be a whole symbol.
                            lerr_d    = 1'b1;
                            w_state_d = W_IDLE;
                        end else begin
                            we_c      = 1'b1;
                            waddr_c   = '0;
                            windex_d  = AW'(1);
                            w_state_d = W_FILL;
                        end
                    end else if (asi_in0.endofpacket) begin
                        w_state_d = W_IDLE;
                    end
                end
            end
            W_FILL: begin
                if (asi_in0.valid) begin
                    if (asi_in0.startofpacket) begin
                        lerr_d = 1'b1;
                        if (asi_in0.endofpacket) begin
                            w_state_d = W_IDLE;
                        end else begin
                            we_c     = 1'b1;
                            waddr_c  = '0;
                            windex_d = AW'(1);
                        end
                    end else begin
                        we_c = 1'b1;
                        if (windex_q == LAST) begin
                            if (asi_in0.endofpacket) begin
                                commit_c  = 1'b1;
                                wbank_d   = ~wbank_q;
                                w_state_d = W_IDLE;
                            end else begin
                                lerr_d    = 1'b1;
                                w_state_d = W_SKIP;
                            end
                        end else if (asi_in0.endofpacket) begin
                            lerr_d    = 1'b1;
                            w_state_d = W_IDLE;
                        end else begin
                            windex_d = windex_q + AW'(1);
                        end
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read side: stream the oldest full bank, chaining straight into the other one.
    always_comb begin
        r_state_d = r_state_q;
        rindex_d  = rindex_q;
        rbank_d   = rbank_q;
        release_c = 1'b0;
        data_d    = data_q;
        valid_d   = valid_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        rnext_c   = rindex_q + AW'(1);
        case (r_state_q)
            R_IDLE: begin
                if (full_q[rbank_q]) begin
                    data_d    = mem[rbank_q][map_idx('0)];
                    valid_d   = 1'b1;
                    sop_d     = 1'b1;
                    eop_d     = 1'b0;
                    rindex_d  = '0;
                    r_state_d = R_SEND;
                end
            end
            R_SEND: begin
                if (aso_out0.ready) begin
                    if (rindex_q == LAST) begin
                        release_c = 1'b1;
                        rbank_d   = ~rbank_q;
                        rindex_d  = '0;
                        if (full_q[~rbank_q]) begin
                            data_d = mem[~rbank_q][map_idx('0)];
                            sop_d  = 1'b1;
                            eop_d  = 1'b0;
                        end else begin
                            valid_d   = 1'b0;
                            sop_d     = 1'b0;
                            eop_d     = 1'b0;
                            r_state_d = R_IDLE;
                        end
                    end else begin
                        rindex_d = rnext_c;
                        data_d   = mem[rbank_q][map_idx(rnext_c)];
                        sop_d    = 1'b0;
                        eop_d    = (rnext_c == LAST);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Commit and release always target opposite banks.
    always_comb begin
        full_d = full_q;
        if (commit_c)  full_d[wbank_q] = 1'b1;
        if (release_c) full_d[rbank_q] = 1'b0;
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            w_state_q <= W_IDLE;
            windex_q  <= '0;
            wbank_q   <= 1'b0;
            r_state_q <= R_IDLE;
            rindex_q  <= '0;
            rbank_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            full_q    <= '0;
            drop_q    <= 1'b0;
            lerr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            windex_q  <= windex_d;
            wbank_q   <= wbank_d;
            r_state_q <= r_state_d;
            rindex_q  <= rindex_d;
            rbank_q   <= rbank_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            full_q    <= full_d;
            drop_q    <= drop_d;
            lerr_q    <= lerr_d;
        end
    end

    // Sample storage; contents are don't-care until the bank's full flag is set.
    always_ff @(posedge clock_clk) begin
        if (we_c) mem[wbank_q][waddr_c] <= asi_in0.data;
    end

endmodule

// File: tb/tb_ofdm_symbol_buffer.sv
// Directed bench for ofdm_symbol_buffer: natural and bit-reversed instances share one stimulus.
// Table of single-packet framing cases plus hand sequences for latency, overflow, stalls and reset.
module tb_ofdm_symbol_buffer;

    localparam int unsigned L  = 64;
    localparam int unsigned DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        int            cyc;
    } beat_t;

    typedef struct {
        int nbeats;
        int eop_at;
        bit gaps;
        int exp_lerr;
        int exp_out;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_sop, in_eop;
    logic [DW-1:0] in_data;
    logic          rdy;
    logic          sd_nat, le_nat, sd_rev, le_rev;

    ofdm_symbol_buffer_if #(.DATA_WIDTH(DW)) in_nat ();
    ofdm_symbol_buffer_if #(.DATA_WIDTH(DW)) in_rev ();
    ofdm_symbol_buffer_if #(.DATA_WIDTH(DW)) out_nat ();
    ofdm_symbol_buffer_if #(.DATA_WIDTH(DW)) out_rev ();

    assign in_nat.data = in_data;  assign in_nat.valid = in_valid;
    assign in_nat.startofpacket = in_sop;  assign in_nat.endofpacket = in_eop;
    assign in_rev.data = in_data;  assign in_rev.valid = in_valid;
    assign in_rev.startofpacket = in_sop;  assign in_rev.endofpacket = in_eop;
    assign out_nat.ready = rdy;
    assign out_rev.ready = rdy;

    ofdm_symbol_buffer #(.OFDM_SYMBOL_LENGTH(L), .DATA_WIDTH(DW), .BIT_REVERSE(1'b0)) u_nat (
        .clock_clk(clk), .reset_reset_n(rst_n), .asi_in0(in_nat), .aso_out0(out_nat),
        .symbol_drop(sd_nat), .length_error(le_nat));

    ofdm_symbol_buffer #(.OFDM_SYMBOL_LENGTH(L), .DATA_WIDTH(DW), .BIT_REVERSE(1'b1)) u_rev (
        .clock_clk(clk), .reset_reset_n(rst_n), .asi_in0(in_rev), .aso_out0(out_rev),
        .symbol_drop(sd_rev), .length_error(le_rev));

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    drop_cnt = 0, lerr_cnt = 0, drop_rev = 0, lerr_rev = 0;
    int    wide_cnt = 0, hold_viol = 0;
    logic  p_valid = 1'b0, p_rdy = 1'b0, p_sop = 1'b0, p_eop = 1'b0, p_le = 1'b0, p_sd = 1'b0;
    logic [DW-1:0] p_data = '0;
    beat_t nat_q[$];
    beat_t rev_q[$];
    bit    rand_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: handshakes, pulse counts and stall stability.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_nat.valid && rdy)
                nat_q.push_back(beat_t'{out_nat.data, out_nat.startofpacket, out_nat.endofpacket, cyc});
            if (out_rev.valid && rdy)
                rev_q.push_back(beat_t'{out_rev.data, out_rev.startofpacket, out_rev.endofpacket, cyc});
            if (sd_nat) drop_cnt <= drop_cnt + 1;
            if (le_nat) lerr_cnt <= lerr_cnt + 1;
            if (sd_rev) drop_rev <= drop_rev + 1;
            if (le_rev) lerr_rev <= lerr_rev + 1;
            if ((le_nat && p_le) || (sd_nat && p_sd)) wide_cnt <= wide_cnt + 1;
            if (p_valid && !p_rdy && (out_nat.valid !== 1'b1 || out_nat.data !== p_data ||
                out_nat.startofpacket !== p_sop || out_nat.endofpacket !== p_eop))
                hold_viol <= hold_viol + 1;
        end
        p_valid <= out_nat.valid;
        p_rdy   <= rdy;
        p_data  <= out_nat.data;
        p_sop   <= out_nat.startofpacket;
        p_eop   <= out_nat.endofpacket;
        p_le    <= le_nat;
        p_sd    <= sd_nat;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int n, input int eop_at, input int base, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 3 == 1)) begin
                in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = 32'(base * 256 + i);
            in_sop   = (i == 0);
            in_eop   = (i == eop_at);
            tick();
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic wait_beats(input int inst, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((inst == 0 ? nat_q.size() : rev_q.size()) >= n) break;
            @(negedge clk);
        end
    endtask

    task automatic check_pkt(input int inst, input int base, input string name);
        beat_t         b;
        int            bad;
        int            idx;
        int            qs;
        logic [5:0]    k6;
        logic [DW-1:0] exp_d;
        string         msg;
        checks++;
        qs = (inst == 0) ? nat_q.size() : rev_q.size();
        if (qs < L) begin
            errors++;
            $display("FAIL %s: got %0d beats, required %0d", name, qs, L);
            if (inst == 0) nat_q.delete(); else rev_q.delete();
        end else begin
            bad = 0;
            msg = "";
            for (int k = 0; k < L; k++) begin
                if (inst == 0) b = nat_q.pop_front(); else b = rev_q.pop_front();
                k6  = 6'(k);
                idx = (inst == 0) ? k : int'({k6[0], k6[1], k6[2], k6[3], k6[4], k6[5]});
                exp_d = 32'(base * 256 + idx);
                if (b.data !== exp_d || b.sop !== (k == 0) || b.eop !== (k == L - 1)) begin
                    if (bad == 0)
                        msg = $sformatf("beat %0d got data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                                        k, b.data, b.sop, b.eop, exp_d, (k == 0), (k == L - 1));
                    bad++;
                end
            end
            if (bad != 0) begin
                errors++;
                $display("FAIL %s: %0d bad beats, first %s", name, bad, msg);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[8];
        int   rexp[5];
        int   l0, d0, gap;

        tv[0] = '{64, 63, 1'b0, 0, 1};
        tv[1] = '{64, 63, 1'b1, 0, 1};
        tv[2] = '{41, 40, 1'b0, 1, 0};
        tv[3] = '{70, -1, 1'b0, 1, 0};
        tv[4] = '{64, 63, 1'b0, 0, 1};
        tv[5] = '{30, 29, 1'b1, 1, 0};
        tv[6] = '{66, 65, 1'b0, 1, 0};
        tv[7] = '{64, 63, 1'b1, 0, 1};
        rexp  = '{0, 32, 16, 48, 8};

        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_nat.valid), 0);
        chk("rst_sop", 32'(out_nat.startofpacket), 0);
        chk("rst_eop", 32'(out_nat.endofpacket), 0);
        chk("rst_data", out_nat.data, 0);
        chk("rst_drop", 32'(sd_nat), 0);
        chk("rst_lerr", 32'(le_nat), 0);
        chk("in_ready", 32'(in_nat.ready), 1);
        rst_n = 1'b1;
        tick();

        // Latency: valid with sop visible one edge after the commit edge.
        send_pkt(64, 63, 1, 1'b0);
        chk("lat_commit_edge_valid", 32'(out_nat.valid), 0);
        tick();
        chk("lat_next_edge_valid", 32'(out_nat.valid), 1);
        chk("lat_next_edge_sop", 32'(out_nat.startofpacket), 1);
        chk("lat_next_edge_data", out_nat.data, 32'h100);
        chk("lat_rev_valid", 32'(out_rev.valid), 1);
        wait_beats(0, L, 300);
        wait_beats(1, L, 300);
        for (int k = 0; k < 5; k++)
            chk($sformatf("rev_order_%0d", k), (rev_q.size() > k) ? rev_q[k].data : 32'hffffffff,
                32'(256 + rexp[k]));
        check_pkt(0, 1, "basic_nat");
        check_pkt(1, 1, "basic_rev");
        repeat (20) tick();

        // Framing table: each vector is one packet followed by a drain window.
        for (int v = 0; v < 8; v++) begin
            l0 = lerr_cnt;
            d0 = drop_cnt;
            send_pkt(tv[v].nbeats, tv[v].eop_at, 16 + v, tv[v].gaps);
            repeat (100) tick();
            chk($sformatf("vec%0d_lerr", v), 32'(lerr_cnt - l0), 32'(tv[v].exp_lerr));
            chk($sformatf("vec%0d_drop", v), 32'(drop_cnt - d0), 0);
            chk($sformatf("vec%0d_beats", v), 32'(nat_q.size()), 32'(int'(L) * tv[v].exp_out));
            if (tv[v].exp_out != 0) begin
                check_pkt(0, 16 + v, $sformatf("vec%0d_nat", v));
                check_pkt(1, 16 + v, $sformatf("vec%0d_rev", v));
            end
            nat_q.delete();
            rev_q.delete();
        end

        // sop inside a fill restarts the bank with the new packet.
        l0 = lerr_cnt;
        send_pkt(10, -1, 40, 1'b0);
        send_pkt(64, 63, 41, 1'b0);
        repeat (100) tick();
        chk("restart_lerr", 32'(lerr_cnt - l0), 1);
        check_pkt(0, 41, "restart_nat");
        check_pkt(1, 41, "restart_rev");
        chk("restart_extra", 32'(nat_q.size()), 0);

        // Overflow with ready low: A and B kept, C dropped.
        l0 = lerr_cnt;
        d0 = drop_cnt;
        rdy = 1'b0;
        send_pkt(64, 63, 50, 1'b0);
        send_pkt(64, 63, 51, 1'b0);
        send_pkt(64, 63, 52, 1'b0);
        repeat (5) tick();
        chk("ovf_drop", 32'(drop_cnt - d0), 1);
        chk("ovf_lerr", 32'(lerr_cnt - l0), 0);
        chk("ovf_no_beats", 32'(nat_q.size()), 0);
        chk("ovf_hold_valid", 32'(out_nat.valid), 1);
        chk("ovf_hold_sop", 32'(out_nat.startofpacket), 1);
        chk("ovf_hold_data", out_nat.data, 32'(50 * 256));
        rdy = 1'b1;
        wait_beats(0, 2 * L, 400);
        wait_beats(1, 2 * L, 400);
        gap = (nat_q.size() >= L + 1) ? (nat_q[L].cyc - nat_q[L-1].cyc) : -1;
        chk("ovf_b2b_gap", 32'(gap), 1);
        check_pkt(0, 50, "ovf_a_nat");
        check_pkt(0, 51, "ovf_b_nat");
        check_pkt(1, 50, "ovf_a_rev");
        check_pkt(1, 51, "ovf_b_rev");
        repeat (100) tick();
        chk("ovf_c_absent", 32'(nat_q.size()), 0);

        // Random ready: stable while stalled, every sample once in order.
        l0 = hold_viol;
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    rdy = 1'($urandom_range(0, 1));
                end
            end
        join_none
        send_pkt(64, 63, 60, 1'b1);
        wait_beats(0, L, 2000);
        wait_beats(1, L, 2000);
        rand_on = 1'b0;
        repeat (3) tick();
        rdy = 1'b1;
        chk("rand_hold_stable", 32'(hold_viol - l0), 0);
        check_pkt(0, 60, "rand_nat");
        check_pkt(1, 60, "rand_rev");
        repeat (20) tick();
        chk("rand_extra", 32'(nat_q.size()), 0);

        // Reset mid-output with both banks holding data.
        rdy = 1'b0;
        send_pkt(64, 63, 70, 1'b0);
        send_pkt(64, 63, 71, 1'b0);
        tick();
        rdy = 1'b1;
        wait_beats(0, 20, 200);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_nat.valid), 0);
        chk("arst_data", out_nat.data, 0);
        chk("arst_sop_eop", 32'({out_nat.startofpacket, out_nat.endofpacket}), 0);
        chk("arst_rev_valid", 32'(out_rev.valid), 0);
        nat_q.delete();
        rev_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (100) tick();
        chk("arst_no_stale", 32'(nat_q.size()), 0);
        send_pkt(64, 63, 72, 1'b0);
        wait_beats(0, L, 300);
        wait_beats(1, L, 300);
        check_pkt(0, 72, "arst_fresh_nat");
        check_pkt(1, 72, "arst_fresh_rev");
        repeat (100) tick();
        chk("arst_extra", 32'(nat_q.size()), 0);

        chk("pulse_width", 32'(wide_cnt), 0);
        chk("rev_lerr_total", 32'(lerr_rev), 32'(lerr_cnt));
        chk("rev_drop_total", 32'(drop_rev), 32'(drop_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
